// File: rtl/cv32e40px_if_queue.sv
// IF/ID decoupling FIFO of decoded fetch packets; flushed on PC redirect.
// Optional performance outputs are enabled by defining CV32E40PX_IFQ_PERF_EN.
module cv32e40px_if_queue #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         halt_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [INSTR_W-1:0]           in_instr_i,
  input  logic [PC_W-1:0]              in_pc_i,
  input  logic                         in_is_compressed_i,
  input  logic                         in_illegal_c_i,
  input  logic                         in_fetch_failed_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [INSTR_W-1:0]           out_instr_o,
  output logic [PC_W-1:0]              out_pc_o,
  output logic                         out_is_compressed_o,
  output logic                         out_illegal_c_o,
  output logic                         out_fetch_failed_o,
`ifdef CV32E40PX_IFQ_PERF_EN
  output logic                         perf_full_stall_o,
  output logic [$clog2(DEPTH+1)-1:0]   perf_max_count_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = INSTR_W + PC_W + 3;

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [DEPTH-1:0]   wr_en;
  logic [ENTRY_W-1:0] in_entry, head_entry;
  logic               full, push, pop;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign in_ready_o = ~rst & ~halt_i & ~flush_i & (~full | out_ready_i);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid_o & out_ready_i & ~flush_i;

  assign in_entry = {in_fetch_failed_i, in_illegal_c_i, in_is_compressed_i, in_pc_i, in_instr_i};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (pop)
        rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      if (push)
        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      for (int i = 0; i < DEPTH; i++)
        if (wr_en[i]) mem_reg[i] <= in_entry;
    end
  end

  // Head is read straight from registers: no in_* to out_* path.
  assign head_entry          = mem_reg[rd_ptr_reg];
  assign out_instr_o         = head_entry[INSTR_W-1:0];
  assign out_pc_o            = head_entry[INSTR_W +: PC_W];
  assign out_is_compressed_o = head_entry[INSTR_W+PC_W];
  assign out_illegal_c_o     = head_entry[INSTR_W+PC_W+1];
  assign out_fetch_failed_o  = head_entry[INSTR_W+PC_W+2];

  assign out_valid_o = (count_reg != '0);
  assign count_o     = count_reg;
  assign empty_o     = (count_reg == '0);
  assign full_o      = full;

`ifdef CV32E40PX_IFQ_PERF_EN
  logic [CNT_W-1:0] perf_max_count_reg;

  assign perf_full_stall_o = in_valid_i & full & ~out_ready_i & ~flush_i & ~halt_i;
  assign perf_max_count_o  = perf_max_count_reg;

  // High-water mark survives flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      perf_max_count_reg <= '0;
    else if (count_next > perf_max_count_reg)
      perf_max_count_reg <= count_next;
  end
`endif

endmodule

// File: tb/tb_cv32e40px_if_queue.sv
// Randomized bench for cv32e40px_if_queue against a queue-based packet model.
module tb_cv32e40px_if_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        ill;
    logic        ff;
  } pkt_t;

  logic clk = 1'b0;
  logic rst, flush_i, halt_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_instr_i, in_pc_i, out_instr_o, out_pc_o;
  logic in_is_compressed_i, in_illegal_c_i, in_fetch_failed_i;
  logic out_is_compressed_o, out_illegal_c_o, out_fetch_failed_o;
  logic [CNT_W-1:0] count_o;
  logic empty_o, full_o;
`ifdef CV32E40PX_IFQ_PERF_EN
  logic perf_full_stall_o;
  logic [CNT_W-1:0] perf_max_count_o;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   max_seen = 0;
  logic [31:0] pc_ctr = 32'h1000;
  pkt_t model_q[$];

  cv32e40px_if_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .halt_i(halt_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .in_is_compressed_i(in_is_compressed_i), .in_illegal_c_i(in_illegal_c_i),
    .in_fetch_failed_i(in_fetch_failed_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
    .out_is_compressed_o(out_is_compressed_o), .out_illegal_c_o(out_illegal_c_o),
    .out_fetch_failed_o(out_fetch_failed_o),
`ifdef CV32E40PX_IFQ_PERF_EN
    .perf_full_stall_o(perf_full_stall_o), .perf_max_count_o(perf_max_count_o),
`endif
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [31:0] instr, input logic [31:0] pc);
    pkt_t p;
    p.instr = instr;
    p.pc    = pc;
    p.c     = $urandom_range(0, 1);
    p.ill   = $urandom_range(0, 1);
    p.ff    = $urandom_range(0, 1);
    return p;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic run_cycle(input logic v, input pkt_t p, input logic ordy,
                           input logic fl, input logic hl);
    logic exp_ready, do_pop, do_push;
    pkt_t head, popped;
    in_valid_i = v;  in_instr_i = p.instr;  in_pc_i = p.pc;
    in_is_compressed_i = p.c;  in_illegal_c_i = p.ill;  in_fetch_failed_i = p.ff;
    out_ready_i = ordy;  flush_i = fl;  halt_i = hl;
    @(negedge clk);
    exp_ready = !fl && !hl && (model_q.size() < DEPTH || ordy);
    check("in_ready",  64'(in_ready_o),  64'(exp_ready));
    check("out_valid", 64'(out_valid_o), 64'(model_q.size() != 0));
    check("count",     64'(count_o),     64'(model_q.size()));
    check("empty",     64'(empty_o),     64'(model_q.size() == 0));
    check("full",      64'(full_o),      64'(model_q.size() == DEPTH));
    if (model_q.size() != 0) begin
      head = model_q[0];
      check("head_instr", 64'(out_instr_o), 64'(head.instr));
      check("head_pc",    64'(out_pc_o),    64'(head.pc));
      check("head_flags", 64'({out_is_compressed_o, out_illegal_c_o, out_fetch_failed_o}),
            64'({head.c, head.ill, head.ff}));
    end
`ifdef CV32E40PX_IFQ_PERF_EN
    check("perf_stall", 64'(perf_full_stall_o),
          64'(v && model_q.size() == DEPTH && !ordy && !fl && !hl));
    check("perf_max", 64'(perf_max_count_o), 64'(max_seen));
`endif
    if (fl) begin
      model_q.delete();
      $display("cyc %0d flush", cyc);
    end else begin
      do_pop  = ordy && model_q.size() != 0;
      do_push = v && exp_ready;
      if (do_pop) begin
        popped = model_q.pop_front();
        $display("cyc %0d pop  pc=%08h", cyc, popped.pc);
      end
      if (do_push) begin
        model_q.push_back(p);
        $display("cyc %0d push pc=%08h", cyc, p.pc);
      end
    end
    if (model_q.size() > max_seen) max_seen = model_q.size();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  pkt_t idle_p;

  initial begin
    idle_p = '0;
    rst = 1'b1;  flush_i = 1'b0;  halt_i = 1'b0;  in_valid_i = 1'b1;  out_ready_i = 1'b0;
    in_instr_i = 32'h13;  in_pc_i = 32'h0;
    in_is_compressed_i = 1'b0;  in_illegal_c_i = 1'b0;  in_fetch_failed_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready",  64'(in_ready_o),  64'd0);
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_count",     64'(count_o),     64'd0);
      check("rst_empty",     64'(empty_o),     64'd1);
      check("rst_out_pc",    64'(out_pc_o),    64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: one push, visible next cycle.
    run_cycle(1'b1, mk_pkt(32'h0000_0013, 32'h80), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, idle_p, 1'b1, 1'b0, 1'b0);

    // Fill with ID stalled, then simultaneous pop+push while full, then drain.
    for (int k = 0; k < DEPTH; k++)
      run_cycle(1'b1, mk_pkt($urandom, 32'(4 * k)), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h14), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h10), 1'b1, 1'b0, 1'b0);
    repeat (DEPTH + 1) run_cycle(1'b0, idle_p, 1'b1, 1'b0, 1'b0);

    // Flush with offer and consumer active, then a lone push.
    run_cycle(1'b1, mk_pkt($urandom, 32'h300), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h304), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h308), 1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h200), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, idle_p, 1'b1, 1'b0, 1'b0);

    // Halt drains without accepting.
    run_cycle(1'b1, mk_pkt($urandom, 32'h400), 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, mk_pkt($urandom, 32'h404), 1'b1, 1'b0, 1'b1);
    run_cycle(1'b0, idle_p, 1'b0, 1'b0, 1'b0);

    // Randomized phases with varying consumer pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int rdy_pct;
      rdy_pct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 80 : 95;
      for (int i = 0; i < 150; i++) begin
        logic v, r, f, h;
        v = ($urandom_range(0, 99) < 75);
        r = ($urandom_range(0, 99) < rdy_pct);
        f = ($urandom_range(0, 99) < 3);
        h = ($urandom_range(0, 99) < 8);
        pc_ctr = pc_ctr + (($urandom_range(0, 1) != 0) ? 32'd2 : 32'd4);
        run_cycle(v, mk_pkt($urandom, pc_ctr), r, f, h);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
